// File: rtl/strip_allocator.sv
// strip_allocator
//   Places rectangles into horizontal strips. Each request's height selects a
//   row of an external strip-ID ROM holding three candidate strips. The
//   candidates are tried in priority order, and the rectangle goes into the
//   first strip with enough width left. Each strip has an 8-bit fill level.
//
//   Ports
//     clk, rst        clock; synchronous active-high reset
//     clr             one-cycle pulse that empties every strip (honoured in IDLE only)
//     req_valid/ready request handshake; req_height[4:0], req_width[7:0]
//     rom_en, rom_addr[3:0]           ROM read strobe and row address
//     rom_id1..3[3:0]                 ROM candidates, valid the cycle after rom_en
//     rsp_valid/ready response handshake; rsp_ok, rsp_strip[3:0], rsp_xoff[7:0]
//     grant_cnt[15:0], reject_cnt[15:0]  saturating statistics counters,
//                                        present only when STRIP_ALLOC_STATS_EN is defined
module strip_allocator #(
   parameter int STRIP_W    = 128,
   parameter int NUM_STRIPS = 13
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [4:0] req_height,
   input  logic [7:0] req_width,
   output logic       rom_en,
   output logic [3:0] rom_addr,
   input  logic [3:0] rom_id1,
   input  logic [3:0] rom_id2,
   input  logic [3:0] rom_id3,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic       rsp_ok,
   output logic [3:0] rsp_strip,
   output logic [7:0] rsp_xoff
`ifdef STRIP_ALLOC_STATS_EN
   ,
   output logic [15:0] grant_cnt,
   output logic [15:0] reject_cnt
`endif
);

   localparam logic [8:0] STRIP_W_L    = 9'(STRIP_W);
   localparam logic [4:0] NUM_STRIPS_L = 5'(NUM_STRIPS);
   localparam logic [3:0] NO_STRIP     = 4'hD;

   typedef enum logic [1:0] {IDLE, LOOKUP, CHECK, RESP} state_t;

   state_t     state, state_d;
   logic [7:0] used [NUM_STRIPS];
   logic [7:0] width_q;
   logic [1:0] k_q;
   logic [3:0] id2_q, id3_q;

   logic       accept, req_ok;
   logic [3:0] cand;
   logic       cand_in_range, cand_fit;
   logic [7:0] cand_used;
   logic [8:0] cand_sum;

   assign req_ready = (state == IDLE) && !clr;
   assign rom_en    = (state == LOOKUP);
   assign rsp_valid = (state == RESP);
   assign accept    = req_valid && req_ready;
   assign req_ok    = (req_height >= 5'd4) && (req_height <= 5'd16) && (req_width != 8'd0);

   // The ROM row is only present during the first CHECK cycle, so id1 is
   // used straight from the ROM then; id2/id3 come from the copies taken
   // in that same cycle.
   // NOTE: every signal written in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      cand = rom_id1;
      case (k_q)
         2'd1:    cand = id2_q;
         2'd2:    cand = id3_q;
         default: cand = rom_id1;
      endcase
      cand_in_range = ({1'b0, cand} < NUM_STRIPS_L);
      cand_used = 8'd0;
      for (int i = 0; i < NUM_STRIPS; i++)
         if (cand == 4'(i)) cand_used = used[i];
      // 9-bit sum: a strip nearly full plus a wide rectangle must not wrap into a fit.
      cand_sum = {1'b0, cand_used} + {1'b0, width_q};
      cand_fit = cand_in_range && (cand_sum <= STRIP_W_L);
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_d;
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (accept) state_d = req_ok ? LOOKUP : RESP;
         LOOKUP:  state_d = CHECK;
         CHECK:   if (cand_fit || (k_q == 2'd2)) state_d = RESP;
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments only. The fill
   // levels are a handful of flops rather than a RAM, so reset and clr can
   // empty every strip in a single cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         width_q   <= 8'd0;
         k_q       <= 2'd0;
         id2_q     <= 4'd0;
         id3_q     <= 4'd0;
         rom_addr  <= 4'd0;
         rsp_ok    <= 1'b0;
         rsp_strip <= 4'd0;
         rsp_xoff  <= 8'd0;
         for (int i = 0; i < NUM_STRIPS; i++) used[i] <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  width_q <= req_width;
                  k_q     <= 2'd0;
                  if (req_ok) begin
                     rom_addr <= (req_height <= 5'd12) ? 4'(req_height - 5'd4) : 4'd9;
                  end else begin
                     rsp_ok    <= 1'b0;
                     rsp_strip <= NO_STRIP;
                     rsp_xoff  <= 8'd0;
                  end
               end else if (clr) begin
                  for (int i = 0; i < NUM_STRIPS; i++) used[i] <= 8'd0;
               end
            end
            CHECK: begin
               if (k_q == 2'd0) begin
                  id2_q <= rom_id2;
                  id3_q <= rom_id3;
               end
               if (cand_fit) begin
                  rsp_ok    <= 1'b1;
                  rsp_strip <= cand;
                  rsp_xoff  <= cand_used;
                  for (int i = 0; i < NUM_STRIPS; i++)
                     if (cand == 4'(i)) used[i] <= cand_sum[7:0];
               end else if (k_q == 2'd2) begin
                  rsp_ok    <= 1'b0;
                  rsp_strip <= NO_STRIP;
                  rsp_xoff  <= 8'd0;
               end else begin
                  k_q <= k_q + 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef STRIP_ALLOC_STATS_EN
   logic grant_ev, reject_ev;
   assign grant_ev  = (state == CHECK) && cand_fit;
   assign reject_ev = ((state == IDLE) && accept && !req_ok) ||
                      ((state == CHECK) && !cand_fit && (k_q == 2'd2));

   always_ff @(posedge clk) begin
      if (rst || ((state == IDLE) && clr)) begin
         grant_cnt  <= 16'd0;
         reject_cnt <= 16'd0;
      end else begin
         if (grant_ev && (grant_cnt != 16'hFFFF))   grant_cnt  <= grant_cnt + 16'd1;
         if (reject_ev && (reject_cnt != 16'hFFFF)) reject_cnt <= reject_cnt + 16'd1;
      end
   end
`endif

endmodule
